// File: rtl/pe_op_sequencer_if.sv
// pe_op_sequencer_if
// Stream + PE bundle around one PE_typeC tile.
//   master : upstream fabric / PE side. Drives operand triples and the PE
//            result-valid. Sees ready, the forwarded operands, the valids and the op.
//   slave  : the sequencer. Accepts triples, forwards them to the PE, drives pe_op.
// Signals
//   s_valid, s_ready, s_inp1..3       upstream valid/ready operand stream
//   pe_inp1..3                        operands to PE inp1..3
//   pe_t_valid_inp1/2                 operand valids to PE
//   pe_op                             PE op code
//   pe_out1_valid                     PE t_valid_out1 (result strobe)
interface pe_op_sequencer_if #(
  parameter int DWIDTH = 64
);
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_inp1;
  logic [DWIDTH-1:0] s_inp2;
  logic [DWIDTH-1:0] s_inp3;
  logic [DWIDTH-1:0] pe_inp1;
  logic [DWIDTH-1:0] pe_inp2;
  logic [DWIDTH-1:0] pe_inp3;
  logic              pe_t_valid_inp1;
  logic              pe_t_valid_inp2;
  logic [2:0]        pe_op;
  logic              pe_out1_valid;

  modport master (
    output s_valid, s_inp1, s_inp2, s_inp3, pe_out1_valid,
    input  s_ready, pe_inp1, pe_inp2, pe_inp3,
           pe_t_valid_inp1, pe_t_valid_inp2, pe_op
  );

  modport slave (
    input  s_valid, s_inp1, s_inp2, s_inp3, pe_out1_valid,
    output s_ready, pe_inp1, pe_inp2, pe_inp3,
           pe_t_valid_inp1, pe_t_valid_inp2, pe_op
  );
endinterface

// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer
// Program sequencer for one double-precision PE_typeC tile. A table of up to
// DEPTH (op, len) entries is run in order: each entry streams len operand
// triples from upstream into the PE under a stable pe_op, then the PE pipeline
// is drained for LATENCY+1 cycles before the op may change, so no in-flight
// result is ever decoded under the wrong op.
// Ports
//   clk, rst          clock, async active-high reset
//   cfg_we/addr/op/len table write port (IDLE/DONE only; dropped while busy)
//   cfg_last          index of last entry, captured at start
//   cfg_err           1-cycle pulse one cycle after a dropped table write
//   start, abort      begin program (IDLE only) / return to IDLE from anywhere
//   bus               stream + PE bundle (slave side)
//   busy, done        ISSUE/DRAIN indicator, completion pulse
//   entry_idx         current table entry
//   result_cnt        saturating count of PE results since last accepted start
module pe_op_sequencer #(
  parameter int DWIDTH  = 64,
  parameter int LATENCY = 16,
  parameter int DEPTH   = 8,
  parameter int LENW    = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [2:0]         cfg_op,
  input  logic [LENW-1:0]    cfg_len,
  input  logic [AW-1:0]      cfg_last,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  pe_op_sequencer_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      entry_idx,
  output logic [LENW+AW-1:0] result_cnt
);

  localparam int            TW        = $clog2(LATENCY + 2);
  localparam logic [TW-1:0] DRAIN_CYC = TW'(LATENCY + 1);
  localparam logic [2:0]    OP_NOP    = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx_q, idx_nxt, idx_inc;
  logic [AW-1:0]   last_q, last_nxt;
  logic [2:0]      op_q, op_nxt;
  logic [LENW-1:0] rem_q, rem_nxt;
  logic [TW-1:0]   tmr_q, tmr_nxt;

  logic [2:0]      op_tab  [DEPTH];
  logic [LENW-1:0] len_tab [DEPTH];

  logic xfer, start_ok, at_last;

  // Handshake: ready only while the current entry still owes elements.
  // Operands and valids go straight through so the PE sees no added latency.
  assign bus.s_ready         = (state == ISSUE) && (rem_q != '0);
  assign xfer                = bus.s_valid && bus.s_ready;
  assign bus.pe_inp1         = bus.s_inp1;
  assign bus.pe_inp2         = bus.s_inp2;
  assign bus.pe_inp3         = bus.s_inp3;
  assign bus.pe_t_valid_inp1 = xfer;
  assign bus.pe_t_valid_inp2 = xfer;
  assign bus.pe_op           = op_q;

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == DONE);
  assign entry_idx = idx_q;

  assign start_ok = start && !abort && (state == IDLE);
  assign at_last  = (idx_q == last_q);
  assign idx_inc  = idx_q + AW'(1);

  // Next-state / datapath
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
    op_nxt    = op_q;
    rem_nxt   = rem_q;
    tmr_nxt   = tmr_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          idx_nxt   = '0;
          last_nxt  = cfg_last;
          op_nxt    = op_tab[0];
          rem_nxt   = len_tab[0];
        end
      end
      ISSUE: begin
        if (rem_q == '0) begin
          // Zero-length entry: nothing was issued under this op, so no drain.
          if (at_last) begin
            state_nxt = DONE;
            op_nxt    = OP_NOP;
          end else begin
            idx_nxt = idx_inc;
            op_nxt  = op_tab[idx_inc];
            rem_nxt = len_tab[idx_inc];
          end
        end else if (xfer) begin
          rem_nxt = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            state_nxt = DRAIN;
            tmr_nxt   = DRAIN_CYC;
          end
        end
      end
      DRAIN: begin
        // Loaded with LATENCY+1, leaves on the cycle the count reaches 1,
        // giving exactly LATENCY+1 cycles of DRAIN with pe_op held.
        if (tmr_q <= TW'(1)) begin
          tmr_nxt = '0;
          if (at_last) begin
            state_nxt = DONE;
            op_nxt    = OP_NOP;
          end else begin
            state_nxt = ISSUE;
            idx_nxt   = idx_inc;
            op_nxt    = op_tab[idx_inc];
            rem_nxt   = len_tab[idx_inc];
          end
        end else begin
          tmr_nxt = tmr_q - TW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        op_nxt    = OP_NOP;
      end
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_nxt = IDLE;
      op_nxt    = OP_NOP;
      rem_nxt   = '0;
      tmr_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      last_q <= '0;
      op_q   <= OP_NOP;
      rem_q  <= '0;
      tmr_q  <= '0;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      last_q <= last_nxt;
      op_q   <= op_nxt;
      rem_q  <= rem_nxt;
      tmr_q  <= tmr_nxt;
    end
  end

  // Program table. Writes only land while not busy; a start in the same
  // cycle as a write still launches with the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_tab[i]  <= OP_NOP;
        len_tab[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      op_tab[cfg_addr]  <= cfg_op;
      len_tab[cfg_addr] <= cfg_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && busy;
  end

  // Results are counted in every state, including after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      result_cnt <= '0;
    else if (start_ok)
      result_cnt <= '0;
    else if (bus.pe_out1_valid && (result_cnt != '1))
      result_cnt <= result_cnt + (LENW+AW)'(1);
  end

endmodule

// File: tb/tb_pe_op_sequencer.sv
module tb_pe_op_sequencer;
  localparam int DWIDTH  = 64;
  localparam int LATENCY = 16;
  localparam int DEPTH   = 8;
  localparam int LENW    = 16;
  localparam int AW      = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [2:0]         cfg_op;
  logic [LENW-1:0]    cfg_len;
  logic [AW-1:0]      cfg_last;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [AW-1:0]      entry_idx;
  logic [LENW+AW-1:0] result_cnt;

  pe_op_sequencer_if #(.DWIDTH(DWIDTH)) bus ();

  pe_op_sequencer #(
    .DWIDTH(DWIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .LENW(LENW), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op), .cfg_len(cfg_len),
    .cfg_last(cfg_last), .cfg_err(cfg_err),
    .start(start), .abort(abort),
    .bus(bus),
    .busy(busy), .done(done), .entry_idx(entry_idx), .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // stimulus / log state
  int         vmode  = 0;   // 0 off, 1 always, 2 one-in-three, 3 random, 4 limited
  int         vlimit = 0;
  int         xq[$];        // transfer cycles
  logic [2:0] oq[$];        // pe_op seen at each transfer
  int         rdy_cycles, done_cnt, done_cyc, err_cnt, pass_bad, start_cyc;
  bit         sched[int];   // PE model: cycle -> result valid

  logic [2:0] p_op  [DEPTH];
  int         p_len [DEPTH];

  function automatic bit produces(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b010) || (op == 3'b011);
  endfunction

  // upstream source and PE result model, driven just after the edge
  always @(posedge clk) begin
    #1;
    case (vmode)
      1:       bus.s_valid = 1'b1;
      2:       bus.s_valid = (cyc % 3 == 0);
      3:       bus.s_valid = 1'($urandom_range(0, 1));
      4:       bus.s_valid = (xq.size() < vlimit);
      default: bus.s_valid = 1'b0;
    endcase
    bus.s_inp1 = {$urandom, $urandom};
    bus.s_inp2 = {$urandom, $urandom};
    bus.s_inp3 = {$urandom, $urandom};
    bus.pe_out1_valid = sched.exists(cyc);
    if (sched.exists(cyc)) sched.delete(cyc);
  end

  // observer, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_valid && bus.s_ready) begin
        xq.push_back(cyc);
        oq.push_back(bus.pe_op);
        if (bus.pe_inp1 !== bus.s_inp1 || bus.pe_inp2 !== bus.s_inp2 ||
            bus.pe_inp3 !== bus.s_inp3) pass_bad++;
      end
      if (bus.pe_t_valid_inp1 !== (bus.s_valid && bus.s_ready) ||
          bus.pe_t_valid_inp2 !== (bus.s_valid && bus.s_ready)) pass_bad++;
      if (bus.pe_t_valid_inp1 === 1'b1 && produces(bus.pe_op))
        sched[cyc + LATENCY] = 1'b1;
      if (bus.s_ready) rdy_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cfg_err) err_cnt++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pe_op"},      bus.pe_op, 4);
    chk({tag, "_s_ready"},    bus.s_ready, 0);
    chk({tag, "_pe_valid"},   bus.pe_t_valid_inp1, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_cfg_err"},    cfg_err, 0);
    chk({tag, "_entry_idx"},  entry_idx, 0);
    chk({tag, "_result_cnt"}, result_cnt, 0);
  endtask

  task automatic load();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      cfg_we   = 1'b1;
      cfg_addr = AW'(i);
      cfg_op   = p_op[i];
      cfg_len  = LENW'(p_len[i]);
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic launch(input int nent, input int mode);
    cfg_last = AW'(nent - 1);
    xq.delete(); oq.delete();
    rdy_cycles = 0; done_cnt = 0; done_cyc = 0; err_cnt = 0; pass_bad = 0;
    vmode = mode;
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
    cfg_last = AW'($urandom);  // must not matter after start
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 1000 && xq.size() < n; i++) @(negedge clk);
    chk("xfer_wait", xq.size() >= n, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vmode = 0;
  endtask

  // Expected outcome from the program alone: element totals, ops per
  // transfer, drain spacing and (with a gap-free source) completion time.
  task automatic check_run(input int nent, input int mode, input int exp_err);
    int nx = 0, nr = 0, ce = 1, bad = 0, k = 0;
    for (int e = 0; e < nent; e++) begin
      nx += p_len[e];
      if (produces(p_op[e])) nr += p_len[e];
      ce += (p_len[e] != 0) ? p_len[e] + LATENCY + 1 : 1;
      for (int j = 0; j < p_len[e]; j++) begin
        if (k < xq.size()) begin
          if (oq[k] !== p_op[e]) bad++;
          if (j == 0 && k > 0 && (xq[k] - xq[k-1]) < LATENCY + 2) bad++;
        end
        k++;
      end
    end
    chk("done_pulses", done_cnt, 1);
    chk("xfers", xq.size(), nx);
    chk("op_per_xfer", bad, 0);
    chk("pass_through", pass_bad, 0);
    chk("result_cnt", result_cnt, nr);
    chk("cfg_err_pulses", err_cnt, exp_err);
    chk("end_pe_op", bus.pe_op, 4);
    chk("end_busy", busy, 0);
    if (p_len[nent-1] != 0 && xq.size() > 0)
      chk("drain_to_done", done_cyc - xq[xq.size()-1], LATENCY + 2);
    if (mode == 1) begin
      chk("done_latency", done_cyc - start_cyc, ce);
      chk("ready_cycles", rdy_cycles, nx);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.pe_out1_valid = 1'b0;
    bus.s_inp1 = '0; bus.s_inp2 = '0; bus.s_inp3 = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_len = '0; cfg_last = '0;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin p_op[i] = 3'b100; p_len[i] = 0; end

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // add, one entry of 4
    p_op[0] = 3'b000; p_len[0] = 4;
    load(); launch(1, 1); wait_done(); check_run(1, 1, 0);

    // mul then macc
    p_op[0] = 3'b010; p_len[0] = 3;
    p_op[1] = 3'b011; p_len[1] = 2;
    load(); launch(2, 1); wait_done(); check_run(2, 1, 0);

    // gapped source, len 5
    p_op[0] = 3'b000; p_len[0] = 5;
    load(); launch(1, 2); wait_done(); check_run(1, 2, 0);

    // zero-length middle entry
    p_op[0] = 3'b000; p_len[0] = 2;
    p_op[1] = 3'b010; p_len[1] = 0;
    p_op[2] = 3'b000; p_len[2] = 1;
    load(); launch(3, 1); wait_done(); check_run(3, 1, 0);

    // table write while busy is dropped; start during drain ignored
    p_op[0] = 3'b000; p_len[0] = 6;
    load(); launch(1, 2);
    repeat (2) @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = '0; cfg_op = 3'b010; cfg_len = 16'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_err_now", cfg_err, 1);
    wait_xfers(6);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(); check_run(1, 2, 1);
    launch(1, 1); wait_done(); check_run(1, 1, 0);

    // abort after 2 of 8
    p_op[0] = 3'b000; p_len[0] = 8;
    load(); vlimit = 2; launch(1, 4);
    wait_xfers(2);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", bus.s_ready, 0);
    chk("abort_pe_op", bus.pe_op, 4);
    chk("abort_done", done, 0);
    vmode = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_xfers", xq.size(), 2);
    chk("abort_results", result_cnt, 2);

    // async reset in the middle of a drain
    p_op[0] = 3'b010; p_len[0] = 3;
    load(); launch(1, 1);
    wait_xfers(3);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    vmode = 0;
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    sched.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // table was cleared by reset: entry 0 is NoP, len 0
    p_op[0] = 3'b100; p_len[0] = 0;
    launch(1, 1); wait_done(); check_run(1, 1, 0);

    // randomized programs
    for (int it = 0; it < 8; it++) begin
      int n, m;
      n = $urandom_range(1, 4);
      m = $urandom_range(1, 3);
      for (int e = 0; e < DEPTH; e++) begin
        p_op[e]  = 3'($urandom_range(0, 4));
        p_len[e] = $urandom_range(0, 6);
      end
      load(); launch(n, m); wait_done(); check_run(n, m, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
